// File: rtl/mark_drop_filter.sv
// Store-and-forward filter that drops any packet carrying a DROP_MARK control word.
// Define MARK_DROP_FILTER_STATS_EN to implement the pkts_passed/pkts_dropped counters.
module mark_drop_filter #(
    parameter int                    DATA_WIDTH    = 64,
    parameter int                    CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int                    BUF_ADDR_BITS = 9,
    parameter logic [CTRL_WIDTH-1:0] DROP_MARK     = 8'h54
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkts_passed,
    output logic [31:0]           pkts_dropped
);

    localparam int DEPTH  = 1 << BUF_ADDR_BITS;
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [BUF_ADDR_BITS:0]   RDY_LIMIT = (BUF_ADDR_BITS + 1)'(DEPTH - 8);
    localparam logic [BUF_ADDR_BITS-1:0] PTR_ONE   = {{(BUF_ADDR_BITS - 1){1'b0}}, 1'b1};

    localparam logic [1:0] IN_HDR     = 2'd0;
    localparam logic [1:0] IN_BODY    = 2'd1;
    localparam logic [1:0] IN_DISCARD = 2'd2;

    logic [WORD_W-1:0]        buf_mem_r [DEPTH];
    logic [1:0]               state_r, state_nxt_s;
    logic [BUF_ADDR_BITS-1:0] wr_ptr_r, wr_ptr_nxt_s, wr_inc_s;
    logic [BUF_ADDR_BITS-1:0] commit_ptr_r, commit_nxt_s;
    logic [BUF_ADDR_BITS-1:0] commit_vis_r, rd_ptr_r, used_s;
    logic                     mark_r, mark_nxt_s;
    logic                     in_rdy_r, out_wr_r;
    logic [DATA_WIDTH-1:0]    out_data_r;
    logic [CTRL_WIDTH-1:0]    out_ctrl_r;
    logic [WORD_W-1:0]        rd_word_s;
    logic                     accept_s, full_s, is_zero_s, is_mark_s, is_eop_s;
    logic                     buf_we_s, pass_inc_s, drop_inc_s;

    assign accept_s  = in_wr & in_rdy_r;
    assign wr_inc_s  = wr_ptr_r + PTR_ONE;
    assign full_s    = (wr_inc_s == rd_ptr_r);
    assign is_zero_s = (in_ctrl == {CTRL_WIDTH{1'b0}});
    assign is_mark_s = (in_ctrl == DROP_MARK);
    assign is_eop_s  = ~is_zero_s & ~is_mark_s;
    assign used_s    = commit_ptr_r - rd_ptr_r;
    assign rd_word_s = buf_mem_r[rd_ptr_r];

    // Input FSM: buffer words, then commit or rewind the packet at its EOP.
    always_comb begin
        state_nxt_s  = state_r;
        wr_ptr_nxt_s = wr_ptr_r;
        commit_nxt_s = commit_ptr_r;
        mark_nxt_s   = mark_r;
        buf_we_s     = 1'b0;
        pass_inc_s   = 1'b0;
        drop_inc_s   = 1'b0;
        if (accept_s) begin
            case (state_r)
                IN_HDR: begin
                    if (full_s) begin
                        wr_ptr_nxt_s = commit_ptr_r;
                        mark_nxt_s   = 1'b0;
                        state_nxt_s  = IN_DISCARD;
                    end else begin
                        buf_we_s     = 1'b1;
                        wr_ptr_nxt_s = wr_inc_s;
                        mark_nxt_s   = mark_r | is_mark_s;
                        state_nxt_s  = is_zero_s ? IN_BODY : IN_HDR;
                    end
                end
                IN_BODY: begin
                    if (is_eop_s) begin
                        // A full buffer leaves no room for the EOP itself, so the packet is lost.
                        if (mark_r || full_s) begin
                            wr_ptr_nxt_s = commit_ptr_r;
                            drop_inc_s   = 1'b1;
                        end else begin
                            buf_we_s     = 1'b1;
                            wr_ptr_nxt_s = wr_inc_s;
                            commit_nxt_s = wr_inc_s;
                            pass_inc_s   = 1'b1;
                        end
                        mark_nxt_s  = 1'b0;
                        state_nxt_s = IN_HDR;
                    end else if (full_s) begin
                        wr_ptr_nxt_s = commit_ptr_r;
                        mark_nxt_s   = 1'b0;
                        state_nxt_s  = IN_DISCARD;
                    end else begin
                        buf_we_s     = 1'b1;
                        wr_ptr_nxt_s = wr_inc_s;
                        mark_nxt_s   = mark_r | is_mark_s;
                    end
                end
                IN_DISCARD: begin
                    if (is_eop_s) begin
                        drop_inc_s  = 1'b1;
                        state_nxt_s = IN_HDR;
                    end else begin
                        state_nxt_s = IN_DISCARD;
                    end
                end
                default: begin
                    wr_ptr_nxt_s = commit_ptr_r;
                    mark_nxt_s   = 1'b0;
                    state_nxt_s  = IN_HDR;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Packet buffer storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_mem_r[wr_ptr_r] <= {in_ctrl, in_data};
        end
    end

    // Input-side state, pointers and the occupancy-based ready flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IN_HDR;
            wr_ptr_r     <= '0;
            commit_ptr_r <= '0;
            commit_vis_r <= '0;
            mark_r       <= 1'b0;
            in_rdy_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            commit_ptr_r <= commit_nxt_s;
            commit_vis_r <= commit_ptr_r;
            mark_r       <= mark_nxt_s;
            in_rdy_r     <= ({1'b0, used_s} < RDY_LIMIT);
        end
    end

    // Output side: one committed word per cycle while downstream is ready.
    // commit_vis_r lags the commit by one cycle, giving the two-cycle EOP-to-output latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r   <= '0;
            out_wr_r   <= 1'b0;
            out_data_r <= '0;
            out_ctrl_r <= '0;
        end else if (out_rdy && (rd_ptr_r != commit_vis_r)) begin
            rd_ptr_r   <= rd_ptr_r + PTR_ONE;
            out_wr_r   <= 1'b1;
            out_data_r <= rd_word_s[DATA_WIDTH-1:0];
            out_ctrl_r <= rd_word_s[WORD_W-1 -: CTRL_WIDTH];
        end else begin
            out_wr_r   <= 1'b0;
        end
    end

    assign in_rdy   = in_rdy_r;
    assign out_wr   = out_wr_r;
    assign out_data = out_data_r;
    assign out_ctrl = out_ctrl_r;

`ifdef MARK_DROP_FILTER_STATS_EN
    logic [31:0] pkts_passed_r, pkts_dropped_r;

    // Packet statistics, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkts_passed_r  <= 32'd0;
            pkts_dropped_r <= 32'd0;
        end else begin
            pkts_passed_r  <= pkts_passed_r + {31'd0, pass_inc_s};
            pkts_dropped_r <= pkts_dropped_r + {31'd0, drop_inc_s};
        end
    end

    assign pkts_passed  = pkts_passed_r;
    assign pkts_dropped = pkts_dropped_r;
`else
    logic stats_unused_s;
    assign stats_unused_s = pass_inc_s ^ drop_inc_s;
    assign pkts_passed    = 32'd0;
    assign pkts_dropped   = 32'd0;
`endif

endmodule

// File: doc/mark_drop_filter.md
MARK_DROP_FILTER -- requirements
Module: mark_drop_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, datapath width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control width.
REQ-003 SHALL have parameter BUF_ADDR_BITS, default 9, log2 of packet buffer depth in words.
REQ-004 SHALL have parameter DROP_MARK, default 8'h54, control value marking a word of a packet to be dropped.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have ports in_data  input  DATA_WIDTH, in_ctrl  input  CTRL_WIDTH, in_wr  input  1: upstream word and write strobe.
REQ-008 SHALL have port in_rdy  output  1  high when a word can be accepted.
REQ-009 SHALL have ports out_data  output  DATA_WIDTH, out_ctrl  output  CTRL_WIDTH, out_wr  output  1: downstream word and strobe.
REQ-010 SHALL have port out_rdy  input  1  downstream can accept a word.
REQ-011 SHALL have ports pkts_passed, pkts_dropped  output  32 each  packet counters.

Function
REQ-012 SHALL store-and-forward: no word of a packet leaves before its last word has been accepted.
REQ-013 Input FSM SHALL have states IN_HDR, IN_BODY, IN_DISCARD; reset state IN_HDR.
REQ-014 IN_HDR: words with ctrl!=0 SHALL be buffered as module headers; first ctrl==0 word SHALL be buffered and move FSM to IN_BODY.
REQ-015 IN_BODY: ctrl==0 SHALL be buffered; ctrl==DROP_MARK SHALL set per-packet flag mark; any other non-zero ctrl is EOP.
REQ-016 On EOP with mark=0: word buffered, commit pointer SHALL advance to write pointer+1, pkts_passed increments, FSM -> IN_HDR.
REQ-017 On EOP with mark=1: write pointer SHALL rewind to commit pointer, EOP not stored, pkts_dropped increments, mark clears, FSM -> IN_HDR.
REQ-018 Buffer full (write pointer+1 == read pointer) with no EOP in the current word: write pointer SHALL rewind to commit pointer, FSM -> IN_DISCARD; IN_DISCARD drops words until EOP, then pkts_dropped increments, FSM -> IN_HDR.
REQ-019 in_rdy SHALL be low only while committed (unsent) data occupies at least depth-8 words; otherwise high.
REQ-020 Output side SHALL read only committed words (read pointer != commit pointer), one per cycle.
REQ-021 out_wr, out_data, out_ctrl SHALL be registered; a word SHALL be issued at an edge only if out_rdy was high and committed data existed in the preceding cycle.
REQ-022 First word of a passed packet SHALL appear on out_* exactly 2 cycles after its EOP was accepted (out_rdy held high).
REQ-023 Words SHALL be forwarded unmodified, in order; DROP_MARK SHALL never appear on out_ctrl.
REQ-024 Commit and output read in the same cycle SHALL both take effect.
REQ-025 Pointers SHALL be BUF_ADDR_BITS wide and wrap modulo depth.
REQ-026 Counters SHALL wrap from 32'hFFFFFFFF to 0.
REQ-027 Simultaneous full condition and EOP on the same word: EOP rule (REQ-016/017) SHALL take precedence if space for that word exists; otherwise REQ-018 applies and the packet is counted dropped.

Reset
REQ-028 While reset=0: out_wr=0, out_data=0, out_ctrl=0, in_rdy=0, pointers=0, mark=0, counters=0, FSM=IN_HDR.
REQ-029 Reset mid-packet SHALL discard all buffered data; after release in_rdy SHALL rise on the next clock edge and input restarts in IN_HDR.

Configuration
REQ-030 With macro MARK_DROP_FILTER_STATS_EN defined, pkts_passed/pkts_dropped SHALL count per REQ-016-018.
REQ-031 Without MARK_DROP_FILTER_STATS_EN, both counter outputs SHALL be constant 0 and no counter flops implemented; filtering unchanged.

Verification
REQ-032 One 8'hFF header, 5 ctrl=0 words, EOP ctrl=8'h01, out_rdy=1 -> all 7 words out unmodified, first out_wr 2 cycles after EOP, pkts_passed=1.
REQ-033 Same packet with words 3-5 ctrl=8'h54 -> no out_wr, pkts_dropped=1; following clean packet forwarded intact.
REQ-034 BUF_ADDR_BITS=4, 20-word packet -> whole packet dropped, pkts_dropped=1; next 4-word packet passes.
REQ-035 Two back-to-back clean packets, out_rdy toggled 1/0 each cycle -> both forwarded in order, no loss or duplication, out_wr only after out_rdy=1 cycles.
REQ-036 Assert reset=0 mid-body with 3 words committed and 2 pending -> outputs 0 immediately, no stale word out after release, counters 0.
REQ-037 Build without MARK_DROP_FILTER_STATS_EN, rerun REQ-032/033 -> identical out_* traffic, counters stay 0.
